channel_scheduler: RTL and testbench

CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

---
 rtl/channel_scheduler.sv | 177 +++++++++++++++++
 tb/tb_channel_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_scheduler.sv
// Time-shares one effect unit between the left and right audio channels.
// Captures samples on word-select edges and issues them with ack or timeout bypass.
module channel_scheduler #(
  parameter int D_WIDTH = 24,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_ws,
  input  logic [D_WIDTH-1:0] i_l_data,
  input  logic [D_WIDTH-1:0] i_r_data,
  output logic               o_fx_req,
  output logic               o_fx_ch,
  output logic [D_WIDTH-1:0] o_fx_data,
  input  logic               i_fx_ack,
  input  logic [D_WIDTH-1:0] i_fx_data,
  output logic [D_WIDTH-1:0] o_l_data,
  output logic [D_WIDTH-1:0] o_r_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nx;
  logic               ws_q;
  logic               l_edge;
  logic               r_edge;
  logic               l_pend;
  logic               r_pend;
  logic [D_WIDTH-1:0] l_buf;
  logic [D_WIDTH-1:0] r_buf;
  logic               l_avail;
  logic               r_avail;
  logic [D_WIDTH-1:0] l_smp;
  logic [D_WIDTH-1:0] r_smp;
  logic               in_idle;
  logic               in_issue;
  logic               grant_l;
  logic               grant_r;
  logic               acked;
  logic               tmo_hit;
  logic [15:0]        cnt;

  // An edge this cycle counts as pending so arbitration sees it at once
  always_comb begin
    l_edge   = i_ws & ~ws_q;
    r_edge   = ~i_ws & ws_q;
    l_avail  = l_pend | l_edge;
    r_avail  = r_pend | r_edge;
    l_smp    = l_edge ? i_l_data : l_buf;
    r_smp    = r_edge ? i_r_data : r_buf;
    in_idle  = (state == IDLE);
    in_issue = (state == ISSUE);
    grant_l  = in_idle & l_avail;
    grant_r  = in_idle & ~l_avail & r_avail;
    acked    = in_issue & i_fx_ack;
    tmo_hit  = in_issue & ~i_fx_ack
             & (cnt == TMO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (l_avail | r_avail) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (acked | tmo_hit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    o_fx_req = in_issue;
    o_busy   = in_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_q      <= i_ws;
      l_pend    <= 1'b0;
      r_pend    <= 1'b0;
      l_buf     <= '0;
      r_buf     <= '0;
      cnt       <= '0;
      o_fx_ch   <= 1'b0;
      o_fx_data <= '0;
      o_l_data  <= '0;
      o_r_data  <= '0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      ws_q <= i_ws;

      if (l_edge) begin
        l_buf <= i_l_data;
      end
      if (r_edge) begin
        r_buf <= i_r_data;
      end

      // A grant consumes the pend flag even if the edge arrives alongside it
      if (grant_l) begin
        l_pend <= 1'b0;
      end else if (l_edge) begin
        l_pend <= 1'b1;
      end
      if (grant_r) begin
        r_pend <= 1'b0;
      end else if (r_edge) begin
        r_pend <= 1'b1;
      end

      if ((l_edge & l_pend) | (r_edge & r_pend)) begin
        o_overrun <= 1'b1;
      end

      if (grant_l) begin
        o_fx_ch   <= 1'b0;
        o_fx_data <= l_smp;
      end else if (grant_r) begin
        o_fx_ch   <= 1'b1;
        o_fx_data <= r_smp;
      end

      if (grant_l | grant_r) begin
        cnt <= '0;
      end else if (in_issue) begin
        cnt <= cnt + 16'd1;
      end

      // Ack beats timeout; timeout forwards the unprocessed sample
      if (acked) begin
        if (o_fx_ch) begin
          o_r_data <= i_fx_data;
        end else begin
          o_l_data <= i_fx_data;
        end
      end else if (tmo_hit) begin
        if (o_fx_ch) begin
          o_r_data <= o_fx_data;
        end else begin
          o_l_data <= o_fx_data;
        end
        o_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_channel_scheduler.sv
// Self-checking bench for channel_scheduler with a request scoreboard.
// Table-driven single transactions plus queue, overrun, timeout and reset sequences.
module tb_channel_scheduler;

  localparam int DW = 24;

  logic          clk;
  logic          reset;
  logic          i_ws;
  logic [DW-1:0] i_l_data;
  logic [DW-1:0] i_r_data;
  logic          o_fx_req;
  logic          o_fx_ch;
  logic [DW-1:0] o_fx_data;
  logic          i_fx_ack;
  logic [DW-1:0] i_fx_data;
  logic [DW-1:0] o_l_data;
  logic [DW-1:0] o_r_data;
  logic          o_busy;
  logic          o_overrun;
  logic          o_timeout;

  channel_scheduler #(
    .D_WIDTH(DW),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_ws     (i_ws),
    .i_l_data (i_l_data),
    .i_r_data (i_r_data),
    .o_fx_req (o_fx_req),
    .o_fx_ch  (o_fx_ch),
    .o_fx_data(o_fx_data),
    .i_fx_ack (i_fx_ack),
    .i_fx_data(i_fx_data),
    .o_l_data (o_l_data),
    .o_r_data (o_r_data),
    .o_busy   (o_busy),
    .o_overrun(o_overrun),
    .o_timeout(o_timeout)
  );

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    logic          ch;
    logic [DW-1:0] smp;
    logic [DW-1:0] res;
    int            dly;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  req_t          exp_q[$];
  req_t          cur_exp;
  logic          req_q = 1'b0;
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;
  vec_t          tbl[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_edge(input logic ch,
                            input logic [DW-1:0] smp,
                            input bit push);
    req_t e;
    if (ch) begin
      i_r_data = smp;
      i_l_data = 24'h5A5A5A;
    end else begin
      i_l_data = smp;
      i_r_data = 24'hA5A5A5;
    end
    i_ws = ~ch;
    if (push) begin
      e.ch = ch;
      e.d  = smp;
      exp_q.push_back(e);
    end
  endtask

  task automatic ack(input int dly, input logic [DW-1:0] res);
    repeat (dly) tick();
    i_fx_ack  = 1'b1;
    i_fx_data = res;
    tick();
    i_fx_ack  = 1'b0;
    i_fx_data = 24'(32'($urandom));
  endtask

  task automatic wait_req(input int bound);
    int k = 0;
    while (!o_fx_req && k < bound) begin
      tick();
      k++;
    end
    chk("wait_req", 32'(o_fx_req), 32'd1);
  endtask

  // Scoreboard: each rising request is matched against the oldest expected one
  initial begin
    forever begin
      @(negedge clk);
      if (o_fx_req && !req_q) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got ch=%0d data=%h expected none",
                   o_fx_ch, o_fx_data);
          cur_exp = {o_fx_ch, o_fx_data};
        end else begin
          cur_exp = exp_q.pop_front();
          chk("req_ch", 32'(o_fx_ch), 32'(cur_exp.ch));
          chk("req_data", 32'(o_fx_data), 32'(cur_exp.d));
        end
      end else if (o_fx_req) begin
        chk("req_hold", 32'({o_fx_ch, o_fx_data}), 32'(cur_exp));
      end
      req_q = o_fx_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    tbl[0] = '{1'b0, 24'h123456, 24'h0ABCDE, 3};
    tbl[1] = '{1'b1, 24'h000111, 24'h222222, 0};
    tbl[2] = '{1'b0, 24'hFFFFFF, 24'h000000, 1};
    tbl[3] = '{1'b1, 24'h800000, 24'h7FFFFF, 5};
    tbl[4] = '{1'b0, 24'h555555, 24'hAAAAAA, 7};
    tbl[5] = '{1'b1, 24'h0F0F0F, 24'hF0F0F0, 2};

    reset     = 1'b1;
    i_ws      = 1'b0;
    i_l_data  = '0;
    i_r_data  = '0;
    i_fx_ack  = 1'b0;
    i_fx_data = '0;
    repeat (3) tick();
    chk("rst_req", 32'(o_fx_req), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_l", 32'(o_l_data), 32'd0);
    chk("rst_r", 32'(o_r_data), 32'd0);
    chk("rst_fxd", 32'(o_fx_data), 32'd0);
    chk("rst_flags", 32'({o_overrun, o_timeout}), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req", 32'(o_fx_req), 32'd0);

    i_fx_ack  = 1'b1;
    i_fx_data = 24'h000BAD;
    tick();
    i_fx_ack  = 1'b0;
    chk("idle_ack_l", 32'(o_l_data), 32'd0);
    chk("idle_ack_r", 32'(o_r_data), 32'd0);
    chk("idle_ack_busy", 32'(o_busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      drive_edge(tbl[i].ch, tbl[i].smp, 1'b1);
      tick();
      chk("latency_req", 32'(o_fx_req), 32'd1);
      chk("latency_busy", 32'(o_busy), 32'd1);
      ack(tbl[i].dly, tbl[i].res);
      if (tbl[i].ch) exp_r = tbl[i].res;
      else exp_l = tbl[i].res;
      chk("vec_req_drop", 32'(o_fx_req), 32'd0);
      chk("vec_l", 32'(o_l_data), 32'(exp_l));
      chk("vec_r", 32'(o_r_data), 32'(exp_r));
      chk("vec_tmo", 32'(o_timeout), 32'd0);
      chk("vec_ovr", 32'(o_overrun), 32'd0);
      tick();
      tick();
    end

    drive_edge(1'b0, 24'h010101, 1'b1);
    tick();
    chk("q_req", 32'(o_fx_req), 32'd1);
    drive_edge(1'b1, 24'h000111, 1'b1);
    tick();
    chk("q_hold_data", 32'(o_fx_data), 32'h010101);
    ack(0, 24'h333333);
    exp_l = 24'h333333;
    chk("q_done_req", 32'(o_fx_req), 32'd0);
    chk("q_l", 32'(o_l_data), 32'(exp_l));
    tick();
    chk("q_gap_req", 32'(o_fx_req), 32'd0);
    tick();
    chk("q_r_req", 32'(o_fx_req), 32'd1);
    chk("q_ovr", 32'(o_overrun), 32'd0);
    ack(1, 24'h444444);
    exp_r = 24'h444444;
    chk("q_r", 32'(o_r_data), 32'(exp_r));
    tick();
    tick();

    drive_edge(1'b0, 24'h0000AA, 1'b1);
    tick();
    drive_edge(1'b1, 24'h000001, 1'b0);
    tick();
    drive_edge(1'b0, 24'h0000BB, 1'b1);
    tick();
    chk("ovr_same_ch", 32'(o_overrun), 32'd0);
    chk("ovr_fxd_stable", 32'(o_fx_data), 32'h0000AA);
    drive_edge(1'b1, 24'h000002, 1'b1);
    tick();
    chk("ovr_set", 32'(o_overrun), 32'd1);
    ack(0, 24'h000111);
    wait_req(10);
    ack(0, 24'h000222);
    wait_req(10);
    ack(0, 24'h000333);
    exp_l = 24'h000222;
    exp_r = 24'h000333;
    chk("ovr_l", 32'(o_l_data), 32'(exp_l));
    chk("ovr_r", 32'(o_r_data), 32'(exp_r));
    chk("ovr_sticky", 32'(o_overrun), 32'd1);
    tick();
    tick();

    drive_edge(1'b0, 24'h7FFFFF, 1'b1);
    tick();
    hi = 0;
    while (o_fx_req && hi < 20) begin
      hi++;
      tick();
    end
    exp_l = 24'h7FFFFF;
    chk("tmo_cycles", 32'(hi), 32'd8);
    chk("tmo_l", 32'(o_l_data), 32'(exp_l));
    chk("tmo_r", 32'(o_r_data), 32'(exp_r));
    chk("tmo_flag", 32'(o_timeout), 32'd1);
    tick();
    tick();
    chk("tmo_sticky", 32'(o_timeout), 32'd1);

    drive_edge(1'b1, 24'h000999, 1'b1);
    tick();
    chk("mid_req", 32'(o_fx_req), 32'd1);
    i_ws  = 1'b1;
    reset = 1'b1;
    tick();
    chk("mid_rst_req", 32'(o_fx_req), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_ch", 32'(o_fx_ch), 32'd0);
    chk("mid_rst_fxd", 32'(o_fx_data), 32'd0);
    chk("mid_rst_l", 32'(o_l_data), 32'd0);
    chk("mid_rst_r", 32'(o_r_data), 32'd0);
    chk("mid_rst_ovr", 32'(o_overrun), 32'd0);
    chk("mid_rst_tmo", 32'(o_timeout), 32'd0);
    tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_no_req", 32'(o_fx_req), 32'd0);
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
